// File: rtl/manch_pkg.sv
// Shared types and timing helpers for the Manchester receive path.
package manch_pkg;

   // Bit-clock recovery states.
   typedef enum logic {
      REC_HUNT = 1'b0,
      REC_LOCK = 1'b1
   } rec_state_t;

   // UART deframer states.
   typedef enum logic [1:0] {
      DFR_IDLE = 2'd0,
      DFR_DATA = 2'd1,
      DFR_STOP = 2'd2
   } dfr_state_t;

   // Decoded bit value seen on an idle line.
   localparam logic IDLE_BIT = 1'b1;

   typedef struct packed {
      logic [31:0] bit_cyc;
      logic [31:0] early;
      logic [31:0] late;
   } timing_t;

   // Bit period and mid-bit acceptance window, in clk cycles.
   function automatic timing_t calc_timing(input int unsigned clk_freq, input int unsigned baud);
      timing_t t;
      t.bit_cyc = clk_freq / baud;
      t.early   = (3 * t.bit_cyc) / 4;
      t.late    = (5 * t.bit_cyc) / 4;
      return t;
   endfunction

endpackage

// File: rtl/manch_bit_recover.sv
// Manchester bit-clock recovery: synchronizer, edge detect, interval timer
// and HUNT/LOCK state machine producing one decoded bit per mid-bit edge.
//
//  state | meaning
//  HUNT  | not locked; waiting for a full-period gap ending in a falling edge (start bit)
//  LOCK  | locked; edges past EARLY are mid-bit and carry data, no edge by LATE drops lock
module manch_bit_recover
   import manch_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 75_000_000,
   parameter int unsigned BAUDRATE = 115200
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic bit_valid,
   output logic bit_val,
   output logic locked,
   output logic manch_err
);

   localparam timing_t     TIM     = calc_timing(CLK_FREQ, BAUDRATE);
   localparam int unsigned EARLY_C = TIM.early;
   localparam int unsigned LATE_C  = TIM.late;
   localparam int unsigned TW      = $clog2(LATE_C + 1);
   localparam logic [TW-1:0] EARLY_T = TW'(EARLY_C);
   localparam logic [TW-1:0] LATE_T  = TW'(LATE_C);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q, prev_d;
   logic [TW-1:0] timer_q, timer_d;
   rec_state_t    state_q, state_d;
   logic          bit_valid_q, bit_valid_d;
   logic          bit_val_q, bit_val_d;
   logic          manch_err_q, manch_err_d;
   logic          edge_det;

   // Next-state logic: timer saturates at LATE so it can never wrap while hunting.
   always_comb begin
      edge_det    = (sync2_q != prev_q);
      sync1_d     = line_in;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      state_d     = state_q;
      timer_d     = (timer_q == LATE_T) ? timer_q : timer_q + TW'(1);
      bit_valid_d = 1'b0;
      bit_val_d   = bit_val_q;
      manch_err_d = 1'b0;
      case (state_q)
         REC_HUNT: begin
            if (edge_det) begin
               timer_d = '0;
               if ((timer_q >= EARLY_T) && !sync2_q) begin
                  state_d     = REC_LOCK;
                  bit_valid_d = 1'b1;
                  bit_val_d   = 1'b0;
               end
            end
         end
         REC_LOCK: begin
            // An accepted edge takes priority over a coincident timeout.
            if (edge_det && (timer_q >= EARLY_T)) begin
               timer_d     = '0;
               bit_valid_d = 1'b1;
               bit_val_d   = sync2_q;
            end else if (timer_q == LATE_T) begin
               state_d     = REC_HUNT;
               manch_err_d = 1'b1;
            end
         end
         default: state_d = REC_HUNT;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         timer_q     <= '0;
         state_q     <= REC_HUNT;
         bit_valid_q <= 1'b0;
         bit_val_q   <= 1'b0;
         manch_err_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         timer_q     <= timer_d;
         state_q     <= state_d;
         bit_valid_q <= bit_valid_d;
         bit_val_q   <= bit_val_d;
         manch_err_q <= manch_err_d;
      end
   end

   assign bit_valid = bit_valid_q;
   assign bit_val   = bit_val_q;
   assign locked    = (state_q == REC_LOCK);
   assign manch_err = manch_err_q;

endmodule

// File: rtl/manch_rx.sv
// Manchester/UART receiver top: bit recovery, 8N1 deframing and a
// single-entry valid/ready output register.
//
//  state | meaning
//  IDLE  | waiting for a start bit (decoded 0)
//  DATA  | shifting in data bits, LSB first
//  STOP  | next decoded bit is the stop bit
module manch_rx
   import manch_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 75_000_000,
   parameter int unsigned BAUDRATE  = 115200,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 line_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 locked,
   output logic                 frame_err,
   output logic                 manch_err,
   output logic                 overrun
);

   localparam int unsigned CW = $clog2(DATA_BITS + 1);

   logic                 bit_valid_w, bit_val_w, manch_err_w;
   dfr_state_t           dfr_q, dfr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 byte_done;

   manch_bit_recover #(
      .CLK_FREQ (CLK_FREQ),
      .BAUDRATE (BAUDRATE)
   ) u_rec (
      .clk       (clk),
      .rst       (rst),
      .line_in   (line_in),
      .bit_valid (bit_valid_w),
      .bit_val   (bit_val_w),
      .locked    (locked),
      .manch_err (manch_err_w)
   );

   // Deframer: one step per decoded bit; loss of lock discards any partial byte.
   always_comb begin
      dfr_d       = dfr_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      byte_done   = 1'b0;
      frame_err_d = 1'b0;
      if (manch_err_w) begin
         dfr_d = DFR_IDLE;
         cnt_d = '0;
      end else if (bit_valid_w) begin
         case (dfr_q)
            DFR_IDLE: begin
               if (bit_val_w != IDLE_BIT) begin
                  dfr_d = DFR_DATA;
                  cnt_d = '0;
               end
            end
            DFR_DATA: begin
               shift_d = {bit_val_w, shift_q[DATA_BITS-1:1]};
               if (cnt_q == CW'(DATA_BITS - 1)) dfr_d = DFR_STOP;
               else                             cnt_d = cnt_q + CW'(1);
            end
            DFR_STOP: begin
               dfr_d = DFR_IDLE;
               if (bit_val_w) byte_done   = 1'b1;
               else           frame_err_d = 1'b1;
            end
            default: dfr_d = DFR_IDLE;
         endcase
      end
   end

   // Output holding register: a completed byte may load in the same cycle the old one is taken.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (byte_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Deframer and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dfr_q       <= DFR_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         dfr_q       <= dfr_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign manch_err = manch_err_w;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_manch_rx.sv
// Bench for manch_rx. Runs with a 20-clk bit period (EARLY 15, LATE 25) so
// the 256-byte soak stays short; line edges are placed on falling clk edges.
`timescale 1ns/1ps
module tb_manch_rx;

   localparam int unsigned CLK_FREQ = 2_000_000;
   localparam int unsigned BAUDRATE = 100_000;
   localparam int          HB       = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       line_in;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, locked, frame_err, manch_err, overrun;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         ready_mode = 1;   // 0 hold low, 1 hold high, 2 toggle every cycle
   logic       jitter = 1'b0;
   logic [7:0] got[$];
   logic [7:0] sent[$];
   int         n_fe = 0, n_me = 0, n_ov = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_n;
      logic [7:0] exp_data;
      int         exp_fe;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   manch_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUDRATE  (BAUDRATE),
      .DATA_BITS (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .line_in   (line_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .locked    (locked),
      .frame_err (frame_err),
      .manch_err (manch_err),
      .overrun   (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Consumer and pulse monitor: set rx_ready for the coming posedge, then record what it accepts.
   initial begin
      rx_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = ~rx_ready;
         endcase
         if (!rst) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) n_fe++;
            if (manch_err) n_me++;
            if (overrun)   n_ov++;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      got.delete();
      n_fe = 0;
      n_me = 0;
      n_ov = 0;
   endtask

   function automatic int half_len();
      return jitter ? (HB - 1 + int'($urandom_range(0, 2))) : HB;
   endfunction

   task automatic send_bit(input logic b);
      line_in = ~b;
      repeat (half_len()) @(negedge clk);
      line_in = b;
      repeat (half_len()) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] lat_byte;

      vecs[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vecs[1] = '{8'h55, 1'b1, 1, 8'h55, 0};
      vecs[2] = '{8'hA3, 1'b1, 1, 8'hA3, 0};
      vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
      vecs[4] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
      vecs[5] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vecs[6] = '{8'h80, 1'b1, 1, 8'h80, 0};
      vecs[7] = '{8'h01, 1'b1, 1, 8'h01, 0};

      rst     = 1'b1;
      line_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {23'd0, rx_valid, locked, frame_err, manch_err, overrun, rx_data}, 32'd0);
      rst = 1'b0;

      // Idle line never offers a full-period gap, so no lock.
      idle(20);
      check("idle_locked", locked, 0);
      check("idle_no_data", got.size(), 0);

      // Table of single frames, each followed by idle bits.
      for (int v = 0; v < 8; v++) begin
         clear_obs();
         send_frame(vecs[v].data, vecs[v].stop);
         idle(2);
         check($sformatf("vec%0d_count", v), got.size(), vecs[v].exp_n);
         if (got.size() > 0) check($sformatf("vec%0d_data", v), got[0], vecs[v].exp_data);
         check($sformatf("vec%0d_frame_err", v), n_fe, vecs[v].exp_fe);
         check($sformatf("vec%0d_other_err", v), n_me + n_ov, 0);
         check($sformatf("vec%0d_locked", v), locked, 1);
         check($sformatf("vec%0d_valid_drained", v), rx_valid, 0);
      end

      // Latency: rx_valid rises on the 4th posedge after the stop-bit mid-bit edge.
      clear_obs();
      lat_byte = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(lat_byte[i]);
      line_in = 1'b0;
      repeat (HB) @(negedge clk);
      line_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("latency_not_before_4", rx_valid, 0);
      @(posedge clk);
      #1 check("latency_at_4", rx_valid, 1);
      check("latency_data", rx_data, 8'h5A);
      @(negedge clk);
      repeat (HB - 4) @(negedge clk);
      idle(2);
      check("latency_accepted", got.size(), 1);

      // Held byte with a second byte arriving: overrun, first byte kept.
      ready_mode = 0;
      clear_obs();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(2);
      check("ovr_valid_held", rx_valid, 1);
      check("ovr_data_held", rx_data, 8'h11);
      check("ovr_pulse_count", n_ov, 1);
      check("ovr_nothing_taken", got.size(), 0);
      ready_mode = 1;
      repeat (4) @(negedge clk);
      check("ovr_accept_count", got.size(), 1);
      if (got.size() > 0) check("ovr_accept_data", got[0], 8'h11);
      check("ovr_valid_dropped", rx_valid, 0);

      // Line stuck high mid-byte: lock lost, partial byte discarded, relock on next start bit.
      clear_obs();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      line_in = 1'b1;
      repeat (4 * HB) @(negedge clk);
      check("stuck_unlocked", locked, 0);
      check("stuck_manch_err", n_me, 1);
      send_frame(8'h7E, 1'b1);
      idle(2);
      check("stuck_recover_count", got.size(), 1);
      if (got.size() > 0) check("stuck_recover_data", got[0], 8'h7E);
      check("stuck_no_frame_err", n_fe, 0);
      check("stuck_relocked", locked, 1);

      // Soak: jittered bit periods, consumer toggling rx_ready every cycle.
      jitter     = 1'b1;
      ready_mode = 2;
      clear_obs();
      sent.delete();
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom_range(0, 255));
         sent.push_back(b);
         send_frame(b, 1'b1);
      end
      idle(3);
      check("soak_count", got.size(), 256);
      for (int i = 0; i < got.size() && i < 256; i++)
         check($sformatf("soak_byte%0d", i), got[i], sent[i]);
      check("soak_errors", n_fe + n_me + n_ov, 0);

      // Reset mid-byte with a byte held: everything clears immediately.
      jitter     = 1'b0;
      ready_mode = 0;
      idle(2);
      clear_obs();
      send_frame(8'hC3, 1'b1);
      idle(1);
      check("rst_pre_valid", rx_valid, 1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check("rst_mid_outputs", {23'd0, rx_valid, locked, frame_err, manch_err, overrun, rx_data}, 32'd0);
      @(negedge clk);
      line_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_obs();
      repeat (10) @(negedge clk);
      check("rst_release_pulses", n_fe + n_me + n_ov, 0);
      check("rst_release_idle", {rx_valid, locked}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
